// File: rtl/spi_slave_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_slave_rx : oversampled SPI receiver with dc tagging and FWFT FIFO  |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module spi_slave_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck,
    input  logic                          mosi,
    input  logic                          cs,
    input  logic                          dc,
    output logic [7:0]                    rx_data,
    output logic                          rx_dc,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [2:0] sck_s;
    logic [2:0] cs_s;
    logic [2:0] mosi_s;
    logic [2:0] dc_s;

    // sck/cs chains reset to their idle-high level so no false edge appears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s  <= 3'b111;
            cs_s   <= 3'b111;
            mosi_s <= 3'b000;
            dc_s   <= 3'b000;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            cs_s   <= {cs_s[1:0], cs};
            mosi_s <= {mosi_s[1:0], mosi};
            dc_s   <= {dc_s[1:0], dc};
        end
    end

    logic unused_sync_bits;
    assign unused_sync_bits = ^{mosi_s[2], dc_s[2]};

    logic rise;
    logic sel;
    logic cs_edge;
    logic cs_rise;

    assign rise    = sck_s[1] & ~sck_s[2];
    assign sel     = ~cs_s[1];
    assign cs_edge = cs_s[1] ^ cs_s[2];
    assign cs_rise = cs_s[1] & ~cs_s[2];

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_done;
    logic [8:0] byte_q;
    logic       ferr_set;

    assign ferr_set = cs_rise & (bit_cnt != 3'd0);

    // Frame boundaries take precedence over a coincident sck rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            byte_done <= 1'b0;
            byte_q    <= 9'd0;
        end else begin
            byte_done <= 1'b0;
            if (cs_edge) begin
                bit_cnt <= 3'd0;
                shreg   <= 7'd0;
            end else if (rise && sel) begin
                shreg   <= {shreg[5:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_q    <= {dc_s[1], shreg, mosi_s[1]};
                end
            end
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;

    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign pop      = rx_valid & rx_ready;
    assign push_ok  = byte_done & (~full | pop);
    assign ovf_set  = byte_done & full & ~pop;
    assign rx_valid = (fifo_count != '0);
    assign rx_dc    = mem[rd_ptr][8];
    assign rx_data  = mem[rd_ptr][7:0];
    assign busy     = sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'd0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= byte_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A set event in the same cycle as clr_err keeps the flag high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr_err) | ovf_set;
            frame_err <= (frame_err & ~clr_err) | ferr_set;
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receive endpoint: the target-side counterpart of the display SPI master. Oversamples `sck`/`mosi`/`cs`/`dc` in the system clock domain, deserialises MSB-first bytes, and tags each byte with the sampled `dc` level. Buffers received bytes in a small FWFT FIFO with a ready/valid read port. Used as a loopback checker and as a command sink for display-emulation logic.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `sck`, input, 1: SPI clock, asynchronous to `clk`; idles high.
- `mosi`, input, 1: serial data, MSB first; changes on falling `sck`.
- `cs`, input, 1: chip select, active-low.
- `dc`, input, 1: data/command flag; sampled together with bit 0.
- `rx_data`, output, 8: head-of-FIFO byte.
- `rx_dc`, output, 1: `dc` tag of the head byte.
- `rx_valid`, output, 1: FIFO non-empty.
- `rx_ready`, input, 1: consumer accepts the head entry when `rx_valid && rx_ready`.
- `fifo_count`, output, log2(FIFO_DEPTH)+1 bits: occupancy.
- `busy`, output, 1: synchronised `cs` is low.
- `overflow`, output, 1: sticky; a byte was dropped because the FIFO was full.
- `frame_err`, output, 1: sticky; `cs` deasserted with a partial byte.
- `clr_err`, input, 1: synchronous pulse that clears `overflow` and `frame_err`.

## Operation
- **Synchronisers**
  - `sck`, `cs`, `mosi` and `dc` each pass through 3-flop chains `x_s[2:0]`.
  - On reset, the `sck` and `cs` chains go to 1 and the `mosi` and `dc` chains go to 0.
- **Edge and select**
  - `rise = sck_s[1] & ~sck_s[2]`.
  - `sel = ~cs_s[1]`.
  - A rise is counted only while `sel` = 1. A rise in the same cycle that `sel` drops to 0 is ignored.
- **Shift**
  - On a counted rise: `shreg <= {shreg[6:0], mosi_s[1]}` and `bit_cnt <= bit_cnt + 1` (3-bit counter).
  - When `bit_cnt` = 7 at the rise, the cycle raises registered `byte_done` for 1 cycle, latches `{dc_s[1], shreg[6:0], mosi_s[1]}`, and wraps `bit_cnt` to 0.
  - Multiple bytes per `cs`-low frame are allowed.
- **Frame boundaries**
  - `cs_s[1]` transitioning in either direction clears `bit_cnt` and `shreg`.
  - If the transition is 0→1 with `bit_cnt` ≠ 0: discard the partial byte and set `frame_err`.
- **FIFO (first-word fall-through)**
  - `byte_done` pushes the entry into the FIFO.
  - If full and no pop in the same cycle: drop the entry, set `overflow`, and leave contents unchanged.
  - Full with a simultaneous pop: the push is accepted and `fifo_count` is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. `fifo_count` is kept separately from the pointers.
- **Sticky flags**
  - `clr_err` clears both flags.
  - A set event in the same cycle as `clr_err` wins; the flag stays 1.
- **Reset values**
  - `rx_valid`, `fifo_count`, `overflow`, `frame_err`, `busy`: 0.
  - `rx_data`, `rx_dc`: 0.
  - `bit_cnt` and pointers: 0.
- **Reset mid-operation**
  - Reset mid-byte or mid-frame discards all state, including FIFO contents.
  - After reset, reception resumes at the next `cs` falling edge.
  - Rises seen before that `cs` fall are ignored, because `cs_s` resets high.

## Timing
- Let E0 be the first `clk` edge that samples `sck` high.
  - The shift occurs at E2.
  - For bit 0, `byte_done` is high after E2 and the FIFO write happens at E3.
  - `rx_valid` rises after E3, i.e. 3 cycles after E0, when the FIFO was empty.
- Pop:
  - `rx_valid && rx_ready` at edge N advances the head.
  - New `rx_data`/`rx_dc` and decremented `fifo_count` are visible after N.
  - `rx_valid` falls after N if that entry was the last.
- `busy` follows `cs` with 2-cycle latency (`~cs_s[1]`).
- Input requirements for correct capture:
  - `sck` high and low phases ≥ 3 `clk` periods each.
  - `mosi`/`dc` stable from the falling `sck` edge through 3 `clk` cycles after the rising edge.
  - The team master's 5-cycle half period meets this.
- Sustained throughput: one byte per 8 `sck` periods. The FIFO absorbs consumer stalls of up to FIFO_DEPTH bytes.

## Test plan
- **Single byte:** `cs` low, send 0xA5 with `dc` = 1, `cs` high, `rx_ready` = 0.
  - `rx_valid` rises 3 cycles after the 8th `sck` rise.
  - `rx_data` = 0xA5, `rx_dc` = 1, `fifo_count` = 1, flags 0.
- **Burst with overflow:** one frame of 6 bytes 0x01..0x06 with `rx_ready` = 0, then drain.
  - `fifo_count` saturates at 4 and `overflow` = 1 after byte 5.
  - The drain yields 0x01..0x04 in order.
- **Partial frame:** `cs` rises after 5 bits.
  - `frame_err` = 1 and no push occurs.
  - The next full byte 0x3C is received intact.
  - `clr_err` then clears `frame_err`.
- **Full with simultaneous pop:** FIFO full with `rx_ready` = 1 in the cycle `byte_done` fires.
  - `fifo_count` stays 4, no overflow, the new byte is at the tail.
- **Reset mid-byte:** assert `reset` after 4 bits, then release.
  - All outputs return to 0.
  - Remaining `sck` rises before the next `cs` fall are ignored.
  - The next frame with 0x81 receives correctly.
